// File: rtl/corner_map_reader.sv
// Raster-scans the FAST corner map in SRAM4 and streams every pixel whose score meets SCORE_MIN
// downstream as an (x, y, score) record through a small credit-protected output FIFO.
module corner_map_reader #(
    parameter int SCORE_MIN  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [8:0]       max_x,
    input  logic [8:0]       max_y,
    input  logic [7:0]       SRAM4_in,
    output logic             read_SRAM4,
    output logic [8:0]       x_addr4,
    output logic [8:0]       y_addr4,
    output logic             corner_valid,
    input  logic             corner_ready,
    output logic [8:0]       corner_x,
    output logic [8:0]       corner_y,
    output logic [7:0]       corner_score,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] corner_count,
    output logic [1:0]       dbg_state_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t           state_q;
    logic [8:0]       mx_q, my_q, x_q, y_q, ret_x_q, ret_y_q;
    logic             rd_q, infl_q, busy_q, done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [25:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    occ_q;

    logic             push, pop, can_issue, at_last;
    logic [CW:0]      pend;
    logic [8:0]       x_nxt, y_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts every record that could still land in the FIFO: stored, returning, and requested.
    always_comb begin
        push      = infl_q && (SRAM4_in >= 8'(SCORE_MIN));
        pop       = (occ_q != '0) && corner_ready;
        pend      = (CW+1)'(occ_q) + (CW+1)'(rd_q) + (CW+1)'(infl_q);
        can_issue = pend < (CW+1)'(FIFO_DEPTH);
        at_last   = (x_q == mx_q) && (y_q == my_q);
        x_nxt     = x_q + 9'd1;
        y_nxt     = y_q;
        if (x_q == mx_q) begin
            x_nxt = 9'd0;
            y_nxt = y_q + 9'd1;
        end
    end

    // x_q/y_q always hold the most recently issued address, so at_last means the scan is fully issued.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            mx_q    <= '0;
            my_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ret_x_q <= '0;
            ret_y_q <= '0;
            rd_q    <= 1'b0;
            infl_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            infl_q  <= rd_q;
            ret_x_q <= x_q;
            ret_y_q <= y_q;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            if (push && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mx_q    <= max_x;
                        my_q    <= max_y;
                        x_q     <= '0;
                        y_q     <= '0;
                        cnt_q   <= '0;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (at_last) begin
                        state_q <= S_DRAIN;
                    end else if (can_issue) begin
                        rd_q <= 1'b1;
                        x_q  <= x_nxt;
                        y_q  <= y_nxt;
                    end
                end
                S_DRAIN: begin
                    if (!rd_q && !infl_q && (occ_q == '0)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= {ret_x_q, ret_y_q, SRAM4_in};
                wp_q        <= ptr_inc(wp_q);
            end
            if (pop) rp_q <= ptr_inc(rp_q);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign read_SRAM4   = rd_q;
    assign x_addr4      = x_q;
    assign y_addr4      = y_q;
    assign corner_valid = (occ_q != '0);
    assign corner_x     = mem_q[rp_q][25:17];
    assign corner_y     = mem_q[rp_q][16:8];
    assign corner_score = mem_q[rp_q][7:0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign corner_count = cnt_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_corner_map_reader.sv
// Bench for corner_map_reader: SRAM model, raster-order reference model, scoreboard monitor.
module tb_corner_map_reader;
  localparam int SCORE_MIN = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic [8:0] max_x = '0, max_y = '0;
  logic [7:0] SRAM4_in;
  logic read_SRAM4;
  logic [8:0] x_addr4, y_addr4;
  logic corner_valid;
  logic corner_ready = 1'b1;
  logic [8:0] corner_x, corner_y;
  logic [7:0] corner_score;
  logic busy, done;
  logic [CNT_W-1:0] corner_count;
  logic [1:0] dbg_state;

  corner_map_reader #(.SCORE_MIN(SCORE_MIN), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .max_x(max_x), .max_y(max_y),
    .SRAM4_in(SRAM4_in), .read_SRAM4(read_SRAM4), .x_addr4(x_addr4), .y_addr4(y_addr4),
    .corner_valid(corner_valid), .corner_ready(corner_ready), .corner_x(corner_x),
    .corner_y(corner_y), .corner_score(corner_score), .busy(busy), .done(done),
    .corner_count(corner_count), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM model ----------------
  logic [7:0] map_q [16][16];
  always @(posedge clk) SRAM4_in <= read_SRAM4 ? map_q[y_addr4[3:0]][x_addr4[3:0]] : 8'($urandom);

  // ---------------- scoreboard state ----------------
  logic [25:0] exp_q[$];
  int exp_t_q[$];
  logic [17:0] rd_exp_q[$];
  int rd_t_q[$];
  int n_cmp = 0, n_err = 0;
  int base = 0, done_cyc = 0, rd_count = 0, exp_done = 0, exp_cnt = 0;
  bit mon_en = 0, timing_chk = 0, done_seen = 0, prev_vr = 0;
  logic [25:0] prev_head;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc - base);
    end
  endtask

  task automatic flag_fail(input string name, input string act, input string req);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %s expected %s (cycle %0d)", name, act, req, cyc - base);
  endtask

  function automatic logic [63:0] all_outputs();
    return {read_SRAM4, x_addr4, y_addr4, corner_valid, corner_x, corner_y, corner_score,
            busy, done, corner_count};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [25:0] head;
    head = {corner_x, corner_y, corner_score};
    if (mon_en) begin
      if (read_SRAM4) begin
        rd_count++;
        if (rd_exp_q.size() == 0) flag_fail("read_extra", "read_SRAM4=1", "no read");
        else begin
          check("read_addr", 64'({x_addr4, y_addr4}), 64'(rd_exp_q.pop_front()));
          if (timing_chk) check("read_cycle", 64'(cyc - base), 64'(rd_t_q[0]));
          void'(rd_t_q.pop_front());
        end
      end
      if (prev_vr) check("head_hold", 64'({corner_valid, head}), 64'({1'b1, prev_head}));
      if (corner_valid && corner_ready) begin
        if (exp_q.size() == 0) flag_fail("record_extra", "corner_valid=1", "no record");
        else begin
          check("record", 64'(head), 64'(exp_q.pop_front()));
          if (timing_chk) check("record_cycle", 64'(cyc - base), 64'(exp_t_q[0]));
          void'(exp_t_q.pop_front());
        end
      end
      if (done) begin
        done_seen = 1;
        done_cyc = cyc - base;
        check("busy_at_done", 64'(busy), 64'(0));
      end
      prev_vr = corner_valid && !corner_ready;
      prev_head = head;
    end else prev_vr = 0;
  end

  // ---------------- driver tasks / reference model ----------------
  task automatic fill_map(input int mode, input logic [7:0] val);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (mode == 0) map_q[y][x] = val;
        else map_q[y][x] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
  endtask

  // Builds the expected raster stream from the map, then pulses start.
  task automatic start_scan(input int mx, input int my, input bit rdy_always);
    int k, n;
    exp_q.delete(); exp_t_q.delete(); rd_exp_q.delete(); rd_t_q.delete();
    rd_count = 0; done_seen = 0; exp_cnt = 0; timing_chk = rdy_always;
    n = (mx + 1) * (my + 1);
    k = 0;
    for (int y = 0; y <= my; y++)
      for (int x = 0; x <= mx; x++) begin
        rd_exp_q.push_back({9'(x), 9'(y)});
        rd_t_q.push_back(k + 1);
        if (int'(map_q[y][x]) >= SCORE_MIN) begin
          exp_q.push_back({9'(x), 9'(y), map_q[y][x]});
          exp_t_q.push_back(k + 3);
          exp_cnt++;
        end
        k++;
      end
    exp_done = (int'(map_q[my][mx]) >= SCORE_MIN) ? n + 4 : n + 3;
    mon_en = 1;
    @(posedge clk); #1;
    max_x = 9'(mx); max_y = 9'(my); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc - 1;
    check("busy_cycle1", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int budget, input bit rand_rdy);
    for (int i = 0; i < budget && !done_seen; i++) begin
      @(posedge clk); #1;
      if (rand_rdy) corner_ready = ($urandom_range(0, 2) != 0);
    end
    corner_ready = 1'b1;
    if (!done_seen) flag_fail("done_timeout", "no done", "done pulse");
    @(posedge clk); #1;
    if (timing_chk) check("done_cycle", 64'(done_cyc), 64'(exp_done));
    check("corner_count", 64'(corner_count), 64'(exp_cnt));
    check("records_left", 64'(exp_q.size()), 64'(0));
    check("reads_left", 64'(rd_exp_q.size()), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // reset with start held high
    n_rst = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 64'(0));
    n_rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_no_read", 64'(read_SRAM4), 64'(0));
    end

    // sparse map
    fill_map(0, 8'd0);
    map_q[0][1] = 8'd20;
    map_q[2][3] = 8'd255;
    start_scan(3, 2, 1);
    wait_done(100, 0);

    // backpressure: consumer stalled for cycles 0..20
    fill_map(0, 8'd5);
    corner_ready = 1'b0;
    start_scan(3, 2, 0);
    while (cyc - base < 21) begin @(posedge clk); #1; end
    check("bp_reads", 64'(rd_count), 64'(4));
    check("bp_head", 64'({corner_valid, corner_x, corner_y, corner_score}),
          64'({1'b1, 9'd0, 9'd0, 8'd5}));
    corner_ready = 1'b1;
    wait_done(200, 0);

    // threshold: nothing qualifies
    fill_map(0, 8'd0);
    start_scan(3, 2, 1);
    wait_done(100, 0);

    // single pixel
    map_q[0][0] = 8'd7;
    start_scan(0, 0, 1);
    wait_done(50, 0);

    // robustness: start pulse mid-scan, then reset at (2,1), then a fresh scan
    fill_map(1, 8'd0);
    start_scan(3, 2, 1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit hit = 0;
      for (int i = 0; i < 30 && !hit; i++) begin
        @(posedge clk); #1;
        hit = read_SRAM4 && (x_addr4 == 9'd2) && (y_addr4 == 9'd1);
      end
      if (!hit) flag_fail("addr_21_timeout", "no read at (2,1)", "read at (2,1)");
    end
    mon_en = 0;
    n_rst = 1'b0;
    @(posedge clk); #1;
    check("midscan_reset_outputs", all_outputs(), 64'(0));
    n_rst = 1'b1;
    start_scan(3, 2, 1);
    wait_done(100, 0);

    // randomized geometries and consumer behaviour
    for (int it = 0; it < 6; it++) begin
      fill_map(1, 8'd0);
      start_scan($urandom_range(0, 5), $urandom_range(0, 4), it[0]);
      wait_done(600, !it[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/corner_map_reader.md
# corner_map_reader

Drains the FAST corner map from SRAM4 after the detector has written it. Scans SRAM4 in raster order and compares each stored score against a threshold. Streams every qualifying pixel downstream as an (x, y, score) record over a valid/ready handshake, for the orientation stage. A small output FIFO and read-credit logic keep one SRAM4 read per cycle when the consumer keeps up, and stall reads cleanly under backpressure.

## Interface
- SCORE_MIN, default 1: a pixel is a corner when its score is ≥ SCORE_MIN (range 0..255).
- FIFO_DEPTH, default 4: depth of the output record FIFO (≥2).
- CNT_W, default 16: width of corner_count.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle pulse; begins a scan when idle.
- max_x  in  9  last column index, sampled on the accepted start.
- max_y  in  9  last row index, sampled on the accepted start.
- SRAM4_in  in  8  read data; valid the cycle after read_SRAM4 is high.
- read_SRAM4  out  1  read strobe, registered.
- x_addr4  out  9  read address column, registered.
- y_addr4  out  9  read address row, registered.
- corner_valid  out  1  FIFO head valid.
- corner_ready  in  1  consumer accepts the head when valid && ready.
- corner_x  out  9  head record column.
- corner_y  out  9  head record row.
- corner_score  out  8  head record score.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse at scan completion.
- corner_count  out  CNT_W  corners pushed in the current or last scan.

## Operation
- States:
  - IDLE: start → SCAN. On entry to SCAN, latch max_x/max_y, zero the address counters and corner_count.
  - SCAN: issue reads. After issuing the address (max_x, max_y) → DRAIN.
  - DRAIN: wait until inflight = 0 and the FIFO is empty → DONE.
  - DONE: done = 1 for one cycle → IDLE.
- Read issue rule in SCAN: issue a read when occupancy + inflight < FIFO_DEPTH, using registered values with no same-cycle pop credit.
- Raster order: x increments 0..max_x; then x wraps to 0 and y increments. max_x = 0 or max_y = 0 is legal (a single column or row).
- inflight: set at the end of an issue cycle, cleared at the end of the data-return cycle unless a new read was issued.
- Data return:
  - If SRAM4_in ≥ SCORE_MIN, push {addr_x, addr_y, SRAM4_in} of the matching read, and corner_count += 1 (saturating at all-ones).
  - Otherwise discard.
  - The issue rule guarantees a push never meets a full FIFO.
- Push and pop in the same cycle: occupancy is unchanged. A pop and a push on an empty FIFO is impossible, because the head is registered.
- While corner_valid && !corner_ready, the head record is held stable.
- start outside IDLE is ignored. The scan parameters cannot change mid-scan.
- corner_count holds after done until the next accepted start.
- Reset (n_rst = 0 at an edge), including mid-scan:
  - state → IDLE; FIFO flushed; inflight dropped.
  - All outputs go to 0: read_SRAM4, x_addr4, y_addr4, corner_valid, corner_x, corner_y, corner_score, busy, done, corner_count.
  - Late SRAM4 data is ignored.

## Timing
- Cycle 0 is the cycle in which start is sampled.
- SCAN occupies cycles 1..N, where N = (max_x+1)(max_y+1). With the consumer always ready, there is one read per cycle and read_SRAM4 is high in cycles 1..N.
- Read in cycle t → data in t+1 → record visible at corner_valid in t+2 (2-cycle read-to-valid latency).
- busy is high in cycles 1 through the last DRAIN cycle. busy = 0 while done = 1.
- done cycle:
  - N+3 if the last pixel is not a corner.
  - N+4 if the last pixel is a corner accepted immediately.
  - Later under backpressure.
- Under backpressure, reads stop once occupancy + inflight = FIFO_DEPTH. The first read resumes in the cycle after the pop that frees a slot.

## Test plan
- Reset: hold n_rst = 0 for 2 cycles with start = 1 → all outputs 0 and no read issued. After release, idle with no start → read_SRAM4 stays 0.
- Sparse map: max_x = 3, max_y = 2, scores 20 at (1,0) and 255 at (3,2), all others 0, ready = 1.
  - Reads: 12 addresses in raster order in cycles 1..12.
  - Records: (1,0,20) valid in cycle 4; (3,2,255) valid in cycle 14.
  - Completion: done in cycle 16; corner_count = 2.
- Backpressure: same 4×3 geometry, all scores 5, ready = 0 for cycles 0..20.
  - Reads stop after 4 issued; head stays (0,0,5) unchanged.
  - Then ready = 1 → 12 records delivered in raster order, none lost or duplicated; corner_count = 12.
- Threshold: all-zero map, SCORE_MIN = 1, max_x = 3, max_y = 2 → corner_valid never high; done in cycle 15; corner_count = 0.
- Single pixel: max_x = max_y = 0, score 7 → exactly one read at (0,0) and one record (0,0,7); done in cycle 5.
- Robustness, on the 4×3 map:
  - Pulse start mid-scan → ignored, no address restart.
  - Assert n_rst at address (2,1) → all outputs 0 next cycle.
  - New start → scan restarts at (0,0); corner_count counts from 0.
